// File: rtl/product_seq_pkg.sv
// Shared types and constants for the nibble-serial multiplier host sequencer.
package product_seq_pkg;

  localparam int unsigned FRAME_LEN  = 6;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned PROD_W     = 2 * BYTE_W;
  localparam int unsigned PHASE_CALC = 4;
  localparam int unsigned PHASE_HI   = 5;
  localparam int unsigned PHASE_W    = 3;

  typedef enum logic [3:0] {
    ST_RST,
    ST_IDLE,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_P5,
    ST_LO
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] a;
    logic [BYTE_W-1:0] b;
  } operand_t;

  // Tile frame phase for a frame state; all-ones means "not inside a frame".
  function automatic logic [PHASE_W-1:0] frame_phase(input state_e st);
    logic [PHASE_W-1:0] ph;
    case (st)
      ST_P0:   ph = PHASE_W'(0);
      ST_P1:   ph = PHASE_W'(1);
      ST_P2:   ph = PHASE_W'(2);
      ST_P3:   ph = PHASE_W'(3);
      ST_P4:   ph = PHASE_W'(4);
      ST_P5:   ph = PHASE_W'(5);
      default: ph = '1;
    endcase
    return ph;
  endfunction

  // Nibble presented to the tile while in frame state st: A hi, A lo, B hi, B lo, then zero.
  function automatic logic [NIB_W-1:0] frame_nibble(input operand_t op, input state_e st);
    logic [PHASE_W-1:0] ph;
    logic [NIB_W-1:0]   nib;
    ph = frame_phase(st);
    if (ph >= PHASE_W'(PHASE_CALC)) begin
      nib = '0;
    end else begin
      case (ph[1:0])
        2'd0:    nib = op.a[BYTE_W-1 -: NIB_W];
        2'd1:    nib = op.a[NIB_W-1:0];
        2'd2:    nib = op.b[BYTE_W-1 -: NIB_W];
        default: nib = op.b[NIB_W-1:0];
      endcase
    end
    return nib;
  endfunction

endpackage

// File: rtl/product_ref_check.sv
// Local reference multiply compared against the tile's {hi,lo} result on strobe.
module product_ref_check
  import product_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic [BYTE_W-1:0] hi,
  input  logic [BYTE_W-1:0] lo,
  input  logic              strobe,
  output logic              err
);

  logic [PROD_W-1:0] ref_c;

  assign ref_c = PROD_W'(a) * PROD_W'(b);
  assign err   = strobe && (ref_c != {hi, lo});

endmodule

// File: rtl/product_host_seq.sv
// Host sequencer: feeds operands to the nibble-serial 8x8 tile and returns its 16-bit product.
// Optional result self-check enabled by defining PRODUCT_SEQ_CHECK_EN.
module product_host_seq
  import product_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              out_err,
  output logic              mul_reset,
  output logic [NIB_W-1:0]  mul_nibble,
  input  logic [BYTE_W-1:0] mul_byte
);

  localparam int unsigned CNT_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  operand_t           op_q, op_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               mul_reset_q, mul_reset_d;
  logic [NIB_W-1:0]   nib_q, nib_d;
  logic               chk_err_c;

`ifdef PRODUCT_SEQ_CHECK_EN
  product_ref_check u_ref_check (
    .a      (op_q.a),
    .b      (op_q.b),
    .hi     (hi_q),
    .lo     (mul_byte),
    .strobe (state_q == ST_LO),
    .err    (chk_err_c)
  );
`else
  assign chk_err_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= '0;
      op_q        <= '0;
      hi_q        <= '0;
      prod_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      mul_reset_q <= 1'b1;
      nib_q       <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      prod_q      <= prod_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      mul_reset_q <= mul_reset_d;
      nib_q       <= nib_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    op_d        = op_q;
    hi_d        = hi_q;
    prod_d      = prod_q;
    valid_d     = valid_q;
    err_d       = err_q;
    ready_d     = 1'b0;
    mul_reset_d = 1'b1;
    nib_d       = '0;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end

    case (state_q)
      ST_RST: begin
        if (rst_cnt_q == CNT_W'(RESET_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (in_valid && ready_q) begin
          op_d    = '{a: in_a, b: in_b};
          state_d = ST_P0;
        end
      end
      ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5: begin
        if (frame_phase(state_q) == PHASE_W'(PHASE_HI)) begin
          hi_d = mul_byte;
        end
        if (frame_phase(state_q) == PHASE_W'(FRAME_LEN - 1)) begin
          state_d = ST_LO;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
      ST_LO: begin
        prod_d  = {hi_q, mul_byte};
        valid_d = 1'b1;
        err_d   = chk_err_c;
        state_d = ST_IDLE;
      end
      default: state_d = ST_RST;
    endcase

    // Outputs are registered from the state being entered, so they line up with that cycle.
    if (frame_phase(state_d) < PHASE_W'(FRAME_LEN)) begin
      mul_reset_d = 1'b0;
    end
    nib_d   = frame_nibble(op_d, state_d);
    ready_d = (state_d == ST_IDLE) && !valid_d;
  end

  assign in_ready    = ready_q;
  assign out_valid   = valid_q;
  assign out_product = prod_q;
  assign out_err     = err_q;
  assign mul_reset   = mul_reset_q;
  assign mul_nibble  = nib_q;

endmodule

// File: tb/tb_product_host_seq.sv
// Directed bench for product_host_seq with a behavioural nibble-serial tile model.
module tb_product_host_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_product;
  logic        out_err;
  logic        mul_reset;
  logic [3:0]  mul_nibble;
  logic [7:0]  mul_byte;

  int checks = 0;
  int errors = 0;

  // Tile model: phase 0..3 shift nibbles, phase 4 multiply, phase 5 hi byte, phase 0 lo byte.
  logic [2:0]  tile_phase = 3'd0;
  logic [15:0] tile_ab = 16'h0000;
  logic [15:0] tile_prod = 16'h0000;
  logic        corrupt = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_reset) begin
      tile_phase <= 3'd0;
    end else begin
      tile_phase <= (tile_phase == 3'd5) ? 3'd0 : tile_phase + 3'd1;
      if (tile_phase < 3'd4) tile_ab <= {tile_ab[11:0], mul_nibble};
      if (tile_phase == 3'd4) tile_prod <= 16'(tile_ab[15:8]) * 16'(tile_ab[7:0]);
    end
  end

  assign mul_byte = (tile_phase == 3'd5) ? (tile_prod[15:8] ^ {7'd0, corrupt}) :
                    (tile_phase == 3'd0) ? tile_prod[7:0] : 8'h00;

  product_host_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_err     (out_err),
    .mul_reset   (mul_reset),
    .mul_nibble  (mul_nibble),
    .mul_byte    (mul_byte)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},    16'(in_ready),    16'd0);
    check({tag, "_out_valid"},   16'(out_valid),   16'd0);
    check({tag, "_out_product"}, out_product,      16'h0000);
    check({tag, "_out_err"},     16'(out_err),     16'd0);
    check({tag, "_mul_reset"},   16'(mul_reset),   16'd1);
    check({tag, "_mul_nibble"},  16'(mul_nibble),  16'd0);
  endtask

  // Issues one op from IDLE and checks the frame cycle by cycle up to the E7 result.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_prod, input logic exp_err);
    logic [3:0] exp_nib [6];
    exp_nib[0] = a[7:4];
    exp_nib[1] = a[3:0];
    exp_nib[2] = b[7:4];
    exp_nib[3] = b[3:0];
    exp_nib[4] = 4'h0;
    exp_nib[5] = 4'h0;
    check("op_in_ready", 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    in_a     = 8'h00;
    in_b     = 8'h00;
    check("c1_in_ready", 16'(in_ready), 16'd0);
    for (int p = 0; p < 6; p++) begin
      check($sformatf("c%0d_mul_reset", p + 1), 16'(mul_reset), 16'd0);
      check($sformatf("c%0d_nibble", p + 1), 16'(mul_nibble), 16'(exp_nib[p]));
      check($sformatf("c%0d_out_valid", p + 1), 16'(out_valid), 16'd0);
      if (p < 5) tick();
    end
    tick();
    check("c7_mul_reset", 16'(mul_reset), 16'd1);
    check("c7_out_valid", 16'(out_valid), 16'd0);
    tick();
    check("e7_out_valid", 16'(out_valid), 16'd1);
    check("e7_product",   out_product,    exp_prod);
    check("e7_out_err",   16'(out_err),   16'(exp_err));
    check("e7_in_ready",  16'(in_ready),  16'd0);
    check("e7_mul_reset", 16'(mul_reset), 16'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    check("drain_out_valid", 16'(out_valid), 16'd0);
    check("drain_out_err",   16'(out_err),   16'd0);
    check("drain_in_ready",  16'(in_ready),  16'd1);
  endtask

  initial begin
    logic exp_corrupt_err;
`ifdef PRODUCT_SEQ_CHECK_EN
    exp_corrupt_err = 1'b1;
`else
    exp_corrupt_err = 1'b0;
`endif

    // Reset values, then in_ready exactly RESET_CYCLES+1 edges after release.
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;
    tick();
    check("rel1_in_ready", 16'(in_ready), 16'd0);
    check("rel1_mul_reset", 16'(mul_reset), 16'd1);
    tick();
    check("rel2_in_ready", 16'(in_ready), 16'd0);
    tick();
    check("rel3_in_ready", 16'(in_ready), 16'd1);

    // Idle with no in_valid: tile stays held, no frame.
    repeat (3) begin
      tick();
      check("idle_mul_reset", 16'(mul_reset), 16'd1);
      check("idle_out_valid", 16'(out_valid), 16'd0);
    end

    do_op(8'd12, 8'd13, 16'h009C, 1'b0);
    drain();
    do_op(8'hFF, 8'hFF, 16'hFE01, 1'b0);
    drain();
    do_op(8'h00, 8'hA5, 16'h0000, 1'b0);
    drain();

    // Backpressure: result held, no accept despite in_valid.
    out_ready = 1'b0;
    do_op(8'hC8, 8'h7B, 16'h6018, 1'b0);
    in_valid = 1'b1;
    in_a     = 8'h11;
    in_b     = 8'h22;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_out_valid", 16'(out_valid), 16'd1);
      check("hold_product",   out_product,    16'h6018);
      check("hold_in_ready",  16'(in_ready),  16'd0);
      check("hold_mul_reset", 16'(mul_reset), 16'd1);
    end
    in_valid = 1'b0;
    drain();

    // Reset pulsed during C3 of an op: result discarded.
    in_valid = 1'b1;
    in_a     = 8'h55;
    in_b     = 8'h66;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midop_mul_reset", 16'(mul_reset), 16'd0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    #2 reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_out_valid", 16'(out_valid), 16'd0);
    end
    do_op(8'd3, 8'd7, 16'h0015, 1'b0);
    drain();

    // Corrupted hi byte from the tile.
    corrupt = 1'b1;
    do_op(8'h5A, 8'h3C, 16'h1418, exp_corrupt_err);
    corrupt = 1'b0;
    drain();
    do_op(8'h80, 8'h02, 16'h0100, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
